det_window_reader: RTL and testbench
====================================

Name: det_window_reader

Overview:
- Consumer-side readout for the fixed-point output of the detector model; it is the reader for the model's output stream.
- Accepts one signed fixed-point sample per clock while enabled and reduces each window of WINDOW samples to min, max, peak-to-peak and mean.
- Hands each window result to downstream logic over a one-deep valid/ready buffer, with a sticky overrun flag when a result is dropped.
- Sits between the model's fixed-point output and the emulator's host/trace logic, replacing per-sample real-valued monitoring.

Parameters:
- WIDTH, 16, bit width of the signed fixed-point sample (same width and exponent as the model output; the exponent is not used inside this block).
- WINDOW, 64, samples per window; power of two, >= 2.
- LOG2_WINDOW, 6, must equal log2(WINDOW); the top level asserts this at elaboration.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  accumulation enable; low discards the partial window.
- samp_valid  input  1  samp carries a new sample this cycle.
- samp  input  WIDTH  signed two's-complement sample.
- res_valid  output  1  result buffer holds an unconsumed result.
- res_ready  input  1  downstream accepts the result this cycle.
- res_min  output  WIDTH  signed window minimum.
- res_max  output  WIDTH  signed window maximum.
- res_pk2pk  output  WIDTH+1  unsigned res_max - res_min.
- res_mean  output  WIDTH  signed floor(sum / WINDOW).
- overrun  output  1  sticky: a completed window was dropped.
- clear_ovr  input  1  clears overrun.

Behaviour:
- Reset (rst=0, any time, asynchronous): count=0; accumulators min=max=sum=0; res_valid=0; all res_* outputs=0; overrun=0. Any in-flight window is lost.
- Accept condition: en && samp_valid && rst. No backpressure on the sample side; a sample is never stalled.
- States:
  - IDLE: en=0. Count and accumulators are held at the empty value.
  - ACC: en=1.
  - IDLE->ACC when en rises. ACC->IDLE when en falls, which discards the partial window (count=0) and produces no result.
- Accumulation:
  - First accepted sample (count=0): min=max=sum=samp (sign-extended).
  - Later samples: min=smin(min,samp), max=smax(max,samp), sum+=samp.
  - sum is signed, WIDTH+LOG2_WINDOW bits, so it cannot overflow.
  - count increments per accepted sample and wraps from WINDOW-1 to 0.
- Window completion: the cycle that accepts the sample with count==WINDOW-1.
  - Final values include that sample.
  - Result registers load on that edge, so res_valid=1 in the following cycle (latency 1 from the last sample).
  - The next window starts on the very next accepted sample; there are no dead cycles.
- Arithmetic:
  - res_mean = sum >>> LOG2_WINDOW (arithmetic shift, rounds toward -inf), truncated to WIDTH bits; this is exact in range.
  - res_pk2pk = max - min computed at WIDTH+1 bits, always >= 0.
- Output handshake:
  - Transfer occurs when res_valid && res_ready.
  - res_* outputs are stable while res_valid=1 and res_ready=0.
  - res_valid drops the cycle after a transfer unless a new result loads on the same edge.
- Completion while the buffer is empty, or full with res_ready=1 the same cycle: the new result loads, res_valid stays/becomes 1, and overrun is unchanged.
- Completion while the buffer is full with res_ready=0: the new result is dropped, the old result is kept, and overrun=1 the next cycle.
- clear_ovr=1 clears overrun on the next edge. If an overrun event occurs in the same cycle, the set wins and overrun stays 1.
- en falling while res_valid=1: the buffered result is kept and still handed off normally.
- samp_valid=0 cycles inside a window do not advance count. Windows are counted in samples, not cycles.

Test Plan:
- WINDOW=4, res_ready=1; samples 10,-3,7,2 -> one cycle after the 4th sample: res_valid=1, min=-3, max=10, pk2pk=13, mean=4 (16>>>2).
- WINDOW=4; samples -1,-1,-1,-2 -> mean=-2 (sum -5, floor), min=-2, max=-1, pk2pk=1; WIDTH=16 with samples 32767,-32768 in one window -> pk2pk=65535.
- WINDOW=4, res_ready=0; 8 samples -> first result held unchanged, overrun=1 after the 8th; raise res_ready -> first result transfers; pulse clear_ovr -> overrun=0.
- Buffer full and res_ready=1 in the same cycle as a window completion -> second result loads with no gap in res_valid, overrun stays 0.
- WINDOW=4; 2 samples, drop en for 1 cycle, re-enable, samples 5,5,5,5 -> exactly one result: min=max=mean=5.
- Assert rst low mid-window and with res_valid=1 -> all outputs 0 immediately (asynchronous); after release, the first full window is correct; samp_valid gaps inside a window do not change the result.

Source files
------------

// File: rtl/det_window_reader.sv
// det_window_reader: window statistics over the detector model's fixed-point output.
// Each window of WINDOW accepted samples is reduced to min, max, peak-to-peak
// and floor mean. The result is handed off through a one-deep valid/ready buffer.
// A completed window that finds the buffer full and not draining is dropped,
// and the sticky overrun flag is set.
module det_window_reader #(
    parameter int WIDTH       = 16,
    parameter int WINDOW      = 64,
    parameter int LOG2_WINDOW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             samp_valid,
    input  logic [WIDTH-1:0] samp,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_min,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH:0]   res_pk2pk,
    output logic [WIDTH-1:0] res_mean,
    output logic             overrun,
    input  logic             clear_ovr
);

    // The sum needs LOG2_WINDOW guard bits so a full window cannot overflow.
    localparam int SUM_W = WIDTH + LOG2_WINDOW;

    generate
        if ((WINDOW < 2) || ((1 << LOG2_WINDOW) != WINDOW)) begin : g_bad_window
            $error("det_window_reader: WINDOW must be a power of two >= 2 equal to 2**LOG2_WINDOW");
        end
    endgenerate

    typedef enum logic {IDLE, ACC} state_t;

    function automatic logic signed [WIDTH-1:0] smin(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                  state;
    logic [LOG2_WINDOW-1:0]  count;
    logic signed [WIDTH-1:0] acc_min;
    logic signed [WIDTH-1:0] acc_max;
    logic signed [SUM_W-1:0] acc_sum;

    logic signed [WIDTH-1:0] samp_s;
    logic                    accept;
    logic                    first;
    logic                    last;
    logic                    load;
    logic                    drop;
    logic signed [WIDTH-1:0] nxt_min;
    logic signed [WIDTH-1:0] nxt_max;
    logic signed [SUM_W-1:0] nxt_sum;
    logic signed [WIDTH:0]   nxt_diff;

    assign samp_s = samp;

    // Next accumulator values, including the sample accepted this cycle.
    always_comb begin
        accept   = en && samp_valid;
        first    = (state == IDLE) || (count == '0);
        last     = accept && (count == LOG2_WINDOW'(WINDOW - 1));
        load     = last && (!res_valid || res_ready);
        drop     = last && res_valid && !res_ready;
        nxt_min  = acc_min;
        nxt_max  = acc_max;
        nxt_sum  = acc_sum;
        if (first) begin
            nxt_min = samp_s;
            nxt_max = samp_s;
            nxt_sum = SUM_W'(samp_s);
        end else begin
            nxt_min = smin(acc_min, samp_s);
            nxt_max = smax(acc_max, samp_s);
            nxt_sum = acc_sum + SUM_W'(samp_s);
        end
        // max >= min, so the WIDTH+1 bit difference is always non-negative.
        nxt_diff = (WIDTH + 1)'(nxt_max) - (WIDTH + 1)'(nxt_min);
    end

    // Enable FSM and window accumulators; dropping en discards the partial window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            acc_min <= '0;
            acc_max <= '0;
            acc_sum <= '0;
        end else begin
            case (state)
                IDLE:    if (en)  state <= ACC;
                ACC:     if (!en) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (!en) begin
                count   <= '0;
                acc_min <= '0;
                acc_max <= '0;
                acc_sum <= '0;
            end else if (accept) begin
                // count wraps from WINDOW-1 to 0, so the next sample starts a new window.
                count   <= count + LOG2_WINDOW'(1);
                acc_min <= nxt_min;
                acc_max <= nxt_max;
                acc_sum <= nxt_sum;
            end
        end
    end

    // One-deep result buffer with sticky overrun; set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_min   <= '0;
            res_max   <= '0;
            res_pk2pk <= '0;
            res_mean  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                res_valid <= 1'b1;
                res_min   <= nxt_min;
                res_max   <= nxt_max;
                res_pk2pk <= nxt_diff;
                // Arithmetic shift by LOG2_WINDOW, then truncate: floor(sum / WINDOW).
                res_mean  <= nxt_sum[LOG2_WINDOW +: WIDTH];
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_det_window_reader.sv
// Bench for det_window_reader with WINDOW=4: directed cases with literal
// expectations plus randomized traffic against a queue-based window model.
module tb_det_window_reader;

    localparam int W   = 16;
    localparam int WIN = 4;
    localparam int LW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          samp_valid = 1'b0;
    logic [W-1:0]  samp = '0;
    logic          res_ready = 1'b0;
    logic          clear_ovr = 1'b0;
    logic          res_valid;
    logic [W-1:0]  res_min;
    logic [W-1:0]  res_max;
    logic [W:0]    res_pk2pk;
    logic [W-1:0]  res_mean;
    logic          overrun;

    det_window_reader #(.WIDTH(W), .WINDOW(WIN), .LOG2_WINDOW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .samp_valid (samp_valid),
        .samp       (samp),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_pk2pk  (res_pk2pk),
        .res_mean   (res_mean),
        .overrun    (overrun),
        .clear_ovr  (clear_ovr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit run_chk     = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q[$];
    bit m_valid;
    bit m_ovr;
    int m_min, m_max, m_pk, m_mean;

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function void model_reset();
        q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_min   = 0;
        m_max   = 0;
        m_pk    = 0;
        m_mean  = 0;
    endfunction

    always @(posedge clk) begin : model_step
        bit load;
        bit drop;
        bit xfer;
        int lo, hi, s;
        load = 1'b0;
        drop = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            xfer = m_valid && res_ready;
            if (!en) begin
                q.delete();
            end else if (samp_valid) begin
                q.push_back(int'($signed(samp)));
                if (q.size() == WIN) begin
                    lo = q[0];
                    hi = q[0];
                    s  = 0;
                    foreach (q[k]) begin
                        if (q[k] < lo) lo = q[k];
                        if (q[k] > hi) hi = q[k];
                        s += q[k];
                    end
                    if (!m_valid || res_ready) begin
                        load   = 1'b1;
                        m_min  = lo;
                        m_max  = hi;
                        m_pk   = hi - lo;
                        m_mean = floor_div(s, WIN);
                    end else begin
                        drop = 1'b1;
                    end
                    q.delete();
                end
            end
            if (load)      m_valid = 1'b1;
            else if (xfer) m_valid = 1'b0;
            if (drop)           m_ovr = 1'b1;
            else if (clear_ovr) m_ovr = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("res_valid", res_valid, m_valid);
            chk("overrun",   overrun,   m_ovr);
            chk("res_min",   $signed(res_min),  m_min);
            chk("res_max",   $signed(res_max),  m_max);
            chk("res_pk2pk", res_pk2pk,         m_pk);
            chk("res_mean",  $signed(res_mean), m_mean);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v);
        en         = 1'b1;
        samp_valid = 1'b1;
        samp       = W'(v);
        tick();
        samp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        samp_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_res(input string tag, input int mn, input int mx, input int pk, input int mean);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_min"},   $signed(res_min),  mn);
        chk({tag, "_max"},   $signed(res_max),  mx);
        chk({tag, "_pk2pk"}, res_pk2pk,         pk);
        chk({tag, "_mean"},  $signed(res_mean), mean);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_ovr"},   overrun,   0);
        chk({tag, "_min"},   res_min,   0);
        chk({tag, "_max"},   res_max,   0);
        chk({tag, "_pk2pk"}, res_pk2pk, 0);
        chk({tag, "_mean"},  res_mean,  0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 chk_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run_chk = 1'b1;

        // Basic window, downstream always ready.
        res_ready = 1'b1;
        send(10); send(-3); send(7); send(2);
        chk_res("t1", -3, 10, 13, 4);
        idle(2);

        // Floor mean of a negative sum.
        send(-1); send(-1); send(-1); send(-2);
        chk_res("t2", -2, -1, 1, -2);
        idle(1);

        // Full-scale span.
        send(32767); send(-32768); send(0); send(0);
        chk_res("t2x", -32768, 32767, 65535, -1);
        idle(2);

        // Overrun: second window dropped, first held.
        res_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(i);
        chk_res("t3", 1, 4, 3, 2);
        chk("t3_ovr_set", overrun, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t3_drained", res_valid, 0);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        chk("t3_ovr_clr", overrun, 0);

        // Completion while full and draining on the same edge.
        send(1); send(2); send(3); send(4);
        send(5); send(6); send(7);
        res_ready = 1'b1;
        send(8);
        chk_res("t4", 5, 8, 3, 6);
        chk("t4_ovr", overrun, 0);
        idle(2);

        // Partial window discarded by en dropping.
        res_ready = 1'b0;
        send(9); send(9);
        en = 1'b0;
        tick();
        send(5); send(5); send(5); send(5);
        chk_res("t5", 5, 5, 0, 5);
        chk("t5_ovr", overrun, 0);

        // Asynchronous reset mid-window with a result buffered.
        send(1); send(2);
        rst = 1'b0;
        model_reset();
        #1 chk_zero("arst");
        @(posedge clk);
        #2 rst = 1'b1;

        // Window with samp_valid gaps.
        send(-7); idle(1); send(3); idle(2); send(100); send(-20);
        chk_res("t6", -20, 100, 120, 19);
        res_ready = 1'b1;
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            en         = ($urandom_range(15) != 0);
            samp_valid = ($urandom_range(3) != 0);
            case ($urandom_range(7))
                0:       samp = 16'sh7fff;
                1:       samp = 16'sh8000;
                default: samp = W'($urandom);
            endcase
            res_ready  = $urandom_range(1);
            clear_ovr  = ($urandom_range(15) == 0);
            if ($urandom_range(499) == 0) begin
                rst = 1'b0;
                model_reset();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        idle(2);
        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
